// File: rtl/fir_pkg.sv
// Shared constants for the time-multiplexed FIR: default widths, control-state
// encoding and the golden coefficient set.
package fir_pkg;

  localparam int unsigned InWidthDef    = 16;
  localparam int unsigned OutWidthDef   = 38;
  localparam int unsigned CoefNumDef    = 64;
  localparam int unsigned LogCoefNumDef = 6;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] CALC = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  // Symmetric low-pass taps; entry 1 must stay -54.
  localparam int CoefTable [64] = '{
    12,    -54,   -31,   40,    77,    -8,    -112,  -66,
    98,    171,   -14,   -233,  -160,  188,   352,   30,
    -420,  -345,  290,   690,   120,   -820,  -760,  510,
    1480,  460,   -2050, -2300, 1650,  6300,  9800,  11200,
    11200, 9800,  6300,  1650,  -2300, -2050, 460,   1480,
    510,   -760,  -820,  120,   690,   290,   -345,  -420,
    30,    352,   188,   -160,  -233,  -14,   171,   98,
    -66,   -112,  -8,    77,    40,    -31,   -54,   12
  };

endpackage

// File: rtl/fir_coef_rom.sv
// Coefficient ROM with a registered read port: data follows the address by one cycle.
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter int unsigned Width    = InWidthDef,
  parameter int unsigned Depth    = CoefNumDef,
  parameter int unsigned AdrWidth = LogCoefNumDef,
  // Fills every word with the most negative value (full-scale characterisation).
  parameter bit          TestRom  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AdrWidth-1:0]     adr,
  output logic signed [Width-1:0] coef
);

  logic [Width-1:0] rom [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_rom
    if (TestRom) begin : g_test
      assign rom[g] = {1'b1, {(Width-1){1'b0}}};
    end else begin : g_gold
      assign rom[g] = Width'(CoefTable[g % 64]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef <= '0;
    end else begin
      coef <= $signed(rom[adr]);
    end
  end

endmodule

// File: rtl/fir_cu.sv
// FIR control unit: sequences IDLE -> LOAD -> CALC (one tap per cycle) -> DONE.
module fir_cu
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       cnt_co,
  output logic [1:0] ps
);

  logic [1:0] ps_d;

  always_comb begin
    ps_d = ps;
    case (ps)
      IDLE:    if (in_valid) ps_d = LOAD;
      LOAD:    ps_d = CALC;
      CALC:    if (cnt_co) ps_d = DONE;
      DONE:    ps_d = IDLE;
      default: ps_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps <= IDLE;
    end else begin
      ps <= ps_d;
    end
  end

endmodule

// File: rtl/fir_dp.sv
// FIR datapath: sample history, coefficient ROM, one multiplier and one accumulator
// stepped through the taps by the tap counter adr.
module fir_dp
  import fir_pkg::*;
#(
  parameter int unsigned InWidth    = InWidthDef,
  parameter int unsigned outWidth   = OutWidthDef,
  parameter int unsigned coefnum    = CoefNumDef,
  parameter int unsigned logcoefnum = LogCoefNumDef,
  parameter bit          TestRom    = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ps,
  input  logic                       in_valid,
  input  logic signed [InWidth-1:0]  inData,
  output logic                       cnt_co,
  output logic                       out_valid,
  output logic signed [outWidth-1:0] outData
);

  localparam int unsigned ProdWidth = 2 * InWidth;

  logic                             accept;
  logic [logcoefnum-1:0]            adr, adr_d;
  logic [coefnum-1:0][InWidth-1:0]  hist;
  logic signed [InWidth-1:0]        coef, sample;
  logic signed [ProdWidth-1:0]      product;
  logic signed [outWidth-1:0]       adder_in1, adder_out, resault;

  assign accept = (ps == IDLE) && in_valid;
  assign cnt_co = (adr == logcoefnum'(coefnum - 1));

  // The ROM and sample registers are addressed with the next adr so that the
  // operands for tap k are already registered on the CALC cycle where adr == k.
  always_comb begin
    adr_d = adr;
    if (accept) begin
      adr_d = '0;
    end else if (ps == CALC) begin
      adr_d = adr + logcoefnum'(1);
    end
  end

  fir_coef_rom #(
    .Width    (InWidth),
    .Depth    (coefnum),
    .AdrWidth (logcoefnum),
    .TestRom  (TestRom)
  ) u_coef_rom (
    .clk  (clk),
    .rst  (rst),
    .adr  (adr_d),
    .coef (coef)
  );

  assign product   = ProdWidth'(coef) * ProdWidth'(sample);
  assign adder_in1 = outWidth'(product);
  assign adder_out = resault + adder_in1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr       <= '0;
      hist      <= '0;
      sample    <= '0;
      resault   <= '0;
      outData   <= '0;
      out_valid <= 1'b0;
    end else begin
      adr       <= adr_d;
      sample    <= $signed(hist[adr_d]);
      out_valid <= (ps == DONE);
      if (accept) begin
        hist    <= {hist[coefnum-2:0], inData};
        resault <= '0;
      end else if (ps == CALC) begin
        resault <= adder_out;
      end
      if (ps == DONE) begin
        outData <= resault;
      end
    end
  end

endmodule

// File: rtl/fir.sv
// Time-multiplexed FIR filter top: one tap per cycle, full-precision signed result.
module fir
  import fir_pkg::*;
#(
  parameter int unsigned InWidth    = InWidthDef,
  // Must equal 2*InWidth + logcoefnum so a full-scale sum cannot overflow.
  parameter int unsigned outWidth   = OutWidthDef,
  parameter int unsigned coefnum    = CoefNumDef,
  parameter int unsigned logcoefnum = LogCoefNumDef,
  parameter bit          TestRom    = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [InWidth-1:0]  inData,
  output logic                       out_valid,
  output logic signed [outWidth-1:0] outData
);

  logic [1:0] ps;
  logic       cnt_co;

  fir_cu CU (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .cnt_co   (cnt_co),
    .ps       (ps)
  );

  fir_dp #(
    .InWidth    (InWidth),
    .outWidth   (outWidth),
    .coefnum    (coefnum),
    .logcoefnum (logcoefnum),
    .TestRom    (TestRom)
  ) DP (
    .clk       (clk),
    .rst       (rst),
    .ps        (ps),
    .in_valid  (in_valid),
    .inData    (inData),
    .cnt_co    (cnt_co),
    .out_valid (out_valid),
    .outData   (outData)
  );

endmodule

// File: tb/tb_fir.sv
// Directed bench for fir: reset, impulse response, latency, full scale, busy/abort
// and a short modelled sample stream.
module tb_fir;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, fs_valid;
  logic signed [15:0] inData, fs_data;
  logic               out_valid, fs_out_valid;
  logic signed [37:0] outData, fs_out;

  int checks = 0;
  int errors = 0;

  int coef_tab [64] = '{
    12,    -54,   -31,   40,    77,    -8,    -112,  -66,
    98,    171,   -14,   -233,  -160,  188,   352,   30,
    -420,  -345,  290,   690,   120,   -820,  -760,  510,
    1480,  460,   -2050, -2300, 1650,  6300,  9800,  11200,
    11200, 9800,  6300,  1650,  -2300, -2050, 460,   1480,
    510,   -760,  -820,  120,   690,   290,   -345,  -420,
    30,    352,   188,   -160,  -233,  -14,   171,   98,
    -66,   -112,  -8,    77,    40,    -31,   -54,   12
  };
  logic signed [15:0] mh [64];

  fir dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inData    (inData),
    .out_valid (out_valid),
    .outData   (outData)
  );

  fir #(.TestRom(1'b1)) dut_fs (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fs_valid),
    .inData    (fs_data),
    .out_valid (fs_out_valid),
    .outData   (fs_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic signed [15:0] s);
    for (int i = 63; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = s;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 64; i++) mh[i] = '0;
  endfunction

  function automatic logic signed [37:0] model();
    longint acc = 0;
    for (int k = 0; k < 64; k++) acc += longint'(coef_tab[k]) * longint'(mh[k]);
    return 38'(acc);
  endfunction

  // Issue one sample and wait for its result; optionally poke in_valid mid-CALC.
  task automatic run_main(input logic [15:0] s, input bit inject,
                          output logic signed [37:0] r);
    int lat;
    @(negedge clk); in_valid = 1'b1; inData = s;
    @(negedge clk); in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk); lat++;
      if (inject && lat == 20) begin in_valid = 1'b1; inData = 16'h7777; end
      if (inject && lat == 21) in_valid = 1'b0;
    end
    r = outData;
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    chk("latency_66_67", {63'd0, (lat >= 66 && lat <= 67)}, 64'd1);
    @(negedge clk);
    chk("pulse_one_cycle", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_fs(input logic [15:0] s, output logic signed [37:0] r);
    int lat;
    @(negedge clk); fs_valid = 1'b1; fs_data = s;
    @(negedge clk); fs_valid = 1'b0; lat = 0;
    while (!fs_out_valid && lat < 200) begin
      @(negedge clk); lat++;
    end
    r = fs_out;
    if (!fs_out_valid) chk("fs_out_valid_seen", {63'd0, fs_out_valid}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic signed [37:0] r, e;
    bit seen, found;

    rst = 1'b1; in_valid = 1'b0; inData = '0; fs_valid = 1'b0; fs_data = '0;
    clear_model();
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_outData", outData, 64'd0);
    chk("reset_ps_idle", {62'd0, dut.CU.ps}, 64'd0);
    chk("reset_fs_outData", fs_out, 64'd0);
    rst = 1'b0;

    // Impulse: results walk through the coefficient table.
    for (int k = 0; k < 64; k++) begin
      run_main((k == 0) ? 16'h0001 : 16'h0000, 1'b0, r);
      e = 38'(coef_tab[k]);
      chk($sformatf("impulse_%0d", k), r, e);
      if (k == 1) begin
        e = -38'sd54;
        chk("impulse_tap1_minus54", r, e);
      end
    end

    // Full scale: (-32768)*(-32768)*64 = 2^36.
    for (int k = 0; k < 64; k++) begin
      run_fs(16'h8000, r);
      if (k == 0) chk("fullscale_first", r, 64'h0000_0000_4000_0000);
      if (k == 63) chk("fullscale_final", r, 64'h0000_0010_0000_0000);
    end

    // Fresh history, then a short modelled stream.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    clear_model();
    begin
      logic [15:0] vec [6] = '{16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0100, 16'hC000};
      for (int i = 0; i < 6; i++) begin
        push(vec[i]);
        run_main(vec[i], 1'b0, r);
        e = model();
        chk($sformatf("stream_%0d", i), r, e);
      end
    end

    // Busy: the mid-CALC strobe must be dropped now and later.
    push(16'h0042);
    run_main(16'h0042, 1'b1, r);
    e = model();
    chk("busy_result", r, e);
    push(16'h0005);
    run_main(16'h0005, 1'b0, r);
    e = model();
    chk("busy_followup", r, e);

    // CALC -> DONE on the cycle after cnt_co, then out_valid.
    push(16'h0010);
    @(negedge clk); in_valid = 1'b1; inData = 16'h0010;
    @(negedge clk); in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dut.CU.ps == 2'b10 && dut.DP.cnt_co) found = 1'b1;
    end
    chk("cnt_co_in_calc", {63'd0, found}, 64'd1);
    @(negedge clk);
    chk("ps_done_after_cnt_co", {62'd0, dut.CU.ps}, 64'd3);
    @(negedge clk);
    chk("valid_after_done", {63'd0, out_valid}, 64'd1);
    e = model();
    chk("done_result", outData, e);
    @(negedge clk);

    // Abort mid-CALC: no pulse, cleared output, zero history afterwards.
    @(negedge clk); in_valid = 1'b1; inData = 16'h5555;
    @(negedge clk); in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {63'd0, seen}, 64'd0);
    chk("abort_ps_idle", {62'd0, dut.CU.ps}, 64'd0);
    chk("abort_outData_zero", outData, 64'd0);
    clear_model();
    push(16'h0003);
    run_main(16'h0003, 1'b0, r);
    e = 38'sd36;
    chk("after_abort_result", r, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
